// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the ARM run sequencer:
//   state_t   - sequencer state encoding (IDLE, RESET, RUN, NEXT, DONE)
//   idx_width - width of the run index for a given number of runs
// ---------------------------------------------------------------------------
package arm_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_RUN   = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // clog2 with a floor of one bit so a single-run sequence still has a
    // run_idx port.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arm_run_sequencer_counter.sv
// ---------------------------------------------------------------------------
// run_cycle_counter
// Up-counter with synchronous clear and count enable, plus a terminal-count
// flag that compares the current count against a supplied limit. The
// sequencer uses one instance for both the RESET and RUN phases by switching
// the limit with the phase.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset
//   clear  in   synchronous clear (takes priority over en)
//   en     in   count enable
//   limit  in   terminal-count value
//   cnt    out  current count
//   tc     out  high while cnt == limit
// ---------------------------------------------------------------------------
module run_cycle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == limit);

endmodule

// File: rtl/arm_run_sequencer.sv
// ---------------------------------------------------------------------------
// arm_run_sequencer
// Drives the ARM core's reset and forwarding-mode pins across NUM_RUNS
// back-to-back runs. Each run: RST_CYCLES of reset, then up to RUN_CYCLES of
// execution (cut short by cpu_halt), then one NEXT cycle. The number of RUN
// cycles of each finished run is reported on perf_cycles with a perf_valid
// pulse. Bit i of MODE_MASK selects forwarding for run i.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   start        in   begin a sequence (honoured only in IDLE or DONE)
//   cpu_halt     in   CPU finished its program; ends the current run
//   cpu_rst      out  active-high reset to the ARM core
//   fwd_en       out  forwarding enable to the ARM core
//   run_idx      out  index of the current run
//   busy         out  high in RESET, RUN and NEXT
//   done         out  sequence complete, sticky until next start
//   perf_valid   out  one-cycle pulse when a run finishes
//   perf_cycles  out  RUN cycles of the last finished run
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | after reset, core held in reset, waiting for start
// RESET   | core held in reset for RST_CYCLES before a run
// RUN     | core released, counting cycles until limit or cpu_halt
// NEXT    | one cycle gap: core back in reset, pick next run or finish
// DONE    | all runs complete, core held in reset, done high
// ---------------------------------------------------------------------------
module arm_run_sequencer
    import arm_pkg::*;
#(
    parameter int                  NUM_RUNS   = 2,
    parameter int                  RST_CYCLES = 1,
    parameter int                  RUN_CYCLES = 350,
    parameter int                  CNT_W      = 16,
    parameter logic [NUM_RUNS-1:0] MODE_MASK  = 2'b01,
    localparam int                 IDX_W      = idx_width(NUM_RUNS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cpu_halt,
    output logic             cpu_rst,
    output logic             fwd_en,
    output logic [IDX_W-1:0] run_idx,
    output logic             busy,
    output logic             done,
    output logic             perf_valid,
    output logic [CNT_W-1:0] perf_cycles
);

    // perf_cycles must be able to hold RUN_CYCLES itself, and the RESET
    // phase shares the same counter.
    if (NUM_RUNS < 1 || RST_CYCLES < 1 || RUN_CYCLES < 1) begin : g_bad_count
        $error("arm_run_sequencer: NUM_RUNS, RST_CYCLES and RUN_CYCLES must be >= 1");
    end
    if (longint'(RUN_CYCLES) > (longint'(1) << CNT_W) - 1 ||
        longint'(RST_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_width
        $error("arm_run_sequencer: CNT_W too narrow for RUN_CYCLES/RST_CYCLES");
    end

    localparam logic [CNT_W-1:0] RST_LIMIT = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(RUN_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_RUNS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    logic             cnt_tc;
    logic             cnt_en;
    logic             cnt_clear;
    logic             run_end;
    logic             last_run;
    logic [IDX_W-1:0] next_idx;

    // The counter only runs in RESET and RUN; it is cleared on every phase
    // boundary so each phase starts counting from zero.
    assign cnt_en    = (state == S_RESET) || (state == S_RUN);
    assign limit     = (state == S_RUN) ? RUN_LIMIT : RST_LIMIT;
    assign run_end   = (state == S_RUN) && (cnt_tc || cpu_halt);
    assign cnt_clear = !cnt_en || cnt_tc || run_end;
    assign last_run  = (run_idx == LAST_IDX);
    assign next_idx  = run_idx + IDX_W'(1);

    run_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (cnt_en),
        .limit (limit),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cpu_rst     <= 1'b1;
            fwd_en      <= MODE_MASK[0];
            run_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            perf_valid  <= 1'b0;
            perf_cycles <= '0;
        end else begin
            perf_valid <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_RESET;
                        run_idx <= '0;
                        fwd_en  <= MODE_MASK[0];
                        done    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_RESET: begin
                    if (cnt_tc) begin
                        state   <= S_RUN;
                        cpu_rst <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Limit and halt in the same cycle give one termination.
                    if (run_end) begin
                        state       <= S_NEXT;
                        cpu_rst     <= 1'b1;
                        perf_valid  <= 1'b1;
                        perf_cycles <= cnt + CNT_W'(1);
                    end
                end
                S_NEXT: begin
                    if (last_run) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        // cpu_rst is already high here, so the mode switch
                        // never reaches a running core.
                        state   <= S_RESET;
                        run_idx <= next_idx;
                        fwd_en  <= MODE_MASK[next_idx];
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cpu_rst <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_run_sequencer.sv
module tb_arm_run_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, halt_a = 1'b0;
    logic        start_b = 1'b0, halt_b = 1'b0;

    logic        cpu_rst_a, fwd_a, busy_a, done_a, pv_a;
    logic [0:0]  idx_a;
    logic [15:0] pc_a;
    logic        cpu_rst_b, fwd_b, busy_b, done_b, pv_b;
    logic [1:0]  idx_b;
    logic [15:0] pc_b;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    arm_run_sequencer u_a (
        .clk(clk), .rst(rst), .start(start_a), .cpu_halt(halt_a),
        .cpu_rst(cpu_rst_a), .fwd_en(fwd_a), .run_idx(idx_a), .busy(busy_a),
        .done(done_a), .perf_valid(pv_a), .perf_cycles(pc_a)
    );

    arm_run_sequencer #(
        .NUM_RUNS(4), .RST_CYCLES(3), .RUN_CYCLES(10), .CNT_W(16),
        .MODE_MASK(4'b1010)
    ) u_b (
        .clk(clk), .rst(rst), .start(start_b), .cpu_halt(halt_b),
        .cpu_rst(cpu_rst_b), .fwd_en(fwd_b), .run_idx(idx_b), .busy(busy_b),
        .done(done_b), .perf_valid(pv_b), .perf_cycles(pc_b)
    );

    // configuration of the two instances: 0 = defaults, 1 = four short runs
    int       cfg_n[2]    = '{2, 4};
    int       cfg_rst[2]  = '{1, 3};
    int       cfg_run[2]  = '{350, 10};
    logic [3:0] cfg_mask[2] = '{4'b0001, 4'b1010};

    // ---------------- reference model ----------------
    // A run is described by t = cycles elapsed since its reset phase began;
    // the first cfg_rst cycles are reset, the rest are run cycles. Once the
    // run has ended, exactly one gap cycle follows.
    bit          m_active[2];
    bit          m_ended[2];
    int          m_t[2];
    int          m_idx[2];
    logic [31:0] m_fwd[2], m_cpu_rst[2], m_busy[2], m_done[2], m_pv[2], m_pc[2];

    task automatic model_reset(input int i);
        m_active[i] = 0; m_ended[i] = 0; m_t[i] = 0; m_idx[i] = 0;
        m_fwd[i] = 32'(cfg_mask[i][0]); m_cpu_rst[i] = 1; m_busy[i] = 0;
        m_done[i] = 0; m_pv[i] = 0; m_pc[i] = 0;
    endtask

    task automatic model_step(input int i, input logic st, input logic h);
        int c;
        m_pv[i] = 0;
        if (!m_active[i]) begin
            if (st) begin
                m_active[i] = 1; m_busy[i] = 1; m_done[i] = 0; m_idx[i] = 0;
                m_fwd[i] = 32'(cfg_mask[i][0]); m_t[i] = 0; m_ended[i] = 0;
            end
        end else if (m_ended[i]) begin
            if (m_idx[i] == cfg_n[i] - 1) begin
                m_active[i] = 0; m_busy[i] = 0; m_done[i] = 1;
            end else begin
                m_idx[i] = m_idx[i] + 1;
                m_fwd[i] = 32'(cfg_mask[i][m_idx[i]]);
                m_t[i] = 0; m_ended[i] = 0;
            end
        end else if (m_t[i] < cfg_rst[i]) begin
            m_t[i] = m_t[i] + 1;
            if (m_t[i] == cfg_rst[i]) m_cpu_rst[i] = 0;
        end else begin
            c = m_t[i] - cfg_rst[i] + 1;
            if (c == cfg_run[i] || h) begin
                m_pv[i] = 1; m_pc[i] = c; m_ended[i] = 1; m_cpu_rst[i] = 1;
            end else begin
                m_t[i] = m_t[i] + 1;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, start_a, halt_a);
            model_step(1, start_b, halt_b);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    logic prev_fwd_a, prev_cr_a, prev_fwd_b, prev_cr_b, prev_rst;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a.cpu_rst", 32'(cpu_rst_a), m_cpu_rst[0]);
            chk("a.fwd_en", 32'(fwd_a), m_fwd[0]);
            chk("a.run_idx", 32'(idx_a), 32'(m_idx[0]));
            chk("a.busy", 32'(busy_a), m_busy[0]);
            chk("a.done", 32'(done_a), m_done[0]);
            chk("a.perf_valid", 32'(pv_a), m_pv[0]);
            chk("a.perf_cycles", 32'(pc_a), m_pc[0]);
            chk("b.cpu_rst", 32'(cpu_rst_b), m_cpu_rst[1]);
            chk("b.fwd_en", 32'(fwd_b), m_fwd[1]);
            chk("b.run_idx", 32'(idx_b), 32'(m_idx[1]));
            chk("b.busy", 32'(busy_b), m_busy[1]);
            chk("b.done", 32'(done_b), m_done[1]);
            chk("b.perf_valid", 32'(pv_b), m_pv[1]);
            chk("b.perf_cycles", 32'(pc_b), m_pc[1]);
            // a mode change must never be visible to a running core
            if (rst && prev_rst && fwd_a != prev_fwd_a)
                chk("a.fwd_change_outside_rst", 32'(cpu_rst_a & prev_cr_a), 1);
            if (rst && prev_rst && fwd_b != prev_fwd_b)
                chk("b.fwd_change_outside_rst", 32'(cpu_rst_b & prev_cr_b), 1);
        end
        prev_fwd_a = fwd_a; prev_cr_a = cpu_rst_a;
        prev_fwd_b = fwd_b; prev_cr_b = cpu_rst_b;
        prev_rst   = rst;
    end

    // per-run record of perf pulses, for the literal expectations
    int pp[2][16];
    int pf[2][16];
    int pi[2][16];
    int pn[2];

    always @(negedge clk) begin
        if (pv_a && pn[0] < 16) begin
            pp[0][pn[0]] = int'(pc_a); pf[0][pn[0]] = int'(fwd_a); pi[0][pn[0]] = int'(idx_a);
            pn[0]++;
        end
        if (pv_b && pn[1] < 16) begin
            pp[1][pn[1]] = int'(pc_b); pf[1][pn[1]] = int'(fwd_b); pi[1][pn[1]] = int'(idx_b);
            pn[1]++;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic cr(input int i);
        return (i == 0) ? cpu_rst_a : cpu_rst_b;
    endfunction

    function automatic logic dn(input int i);
        return (i == 0) ? done_a : done_b;
    endfunction

    task automatic set_start(input int i, input logic v);
        if (i == 0) start_a = v; else start_b = v;
    endtask

    task automatic set_halt(input int i, input logic v);
        if (i == 0) halt_a = v; else halt_b = v;
    endtask

    task automatic clear_log(input int i);
        pn[i] = 0;
    endtask

    // pulse start, then count cycles with cpu_rst high until the first RUN cycle
    task automatic start_count(input int i, output int k);
        set_start(i, 1'b1);
        @(negedge clk);
        set_start(i, 1'b0);
        k = 0;
        while (cr(i) && k < 1000) begin
            k++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int i, input int budget, input string nm);
        int k;
        k = 0;
        while (!dn(i) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({nm, ".done_reached"}, 32'(dn(i)), 1);
    endtask

    task automatic run_random(input int i, input int budget, input int halt_odds);
        int k;
        bit seen;
        seen = 0;
        set_start(i, 1'b1);
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (dn(i) && k > 0) begin
                seen = 1;
                break;
            end
            set_start(i, $urandom_range(0, 15) == 0);
            set_halt(i, $urandom_range(0, halt_odds - 1) == 0);
        end
        set_start(i, 1'b0);
        set_halt(i, 1'b0);
        chk("rand.done_reached", 32'(seen), 1);
    endtask

    // ---------------- main sequence ----------------
    int k;

    initial begin
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst.cpu_rst_a", 32'(cpu_rst_a), 1);
        chk("rst.fwd_a", 32'(fwd_a), 1);
        chk("rst.fwd_b", 32'(fwd_b), 0);
        chk("rst.busy_a", 32'(busy_a), 0);
        chk("rst.done_b", 32'(done_b), 0);
        chk("rst.perf_cycles_a", 32'(pc_a), 0);
        #1 rst = 1'b1;
        @(negedge clk);

        // defaults: two full runs, with a start pulse while busy
        clear_log(0);
        start_count(0, k);
        chk("s1.reset_len", k, 1);
        repeat (20) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, 1000, "s1");
        chk("s1.npulses", pn[0], 2);
        chk("s1.perf0", pp[0][0], 350);
        chk("s1.perf1", pp[0][1], 350);
        chk("s1.fwd0", pf[0][0], 1);
        chk("s1.fwd1", pf[0][1], 0);
        chk("s1.idx1", pi[0][1], 1);
        chk("s1.busy_done", 32'(busy_a), 0);
        chk("s1.cpu_rst_done", 32'(cpu_rst_a), 1);

        // restart from DONE, halt in the 120th RUN cycle of run0
        clear_log(0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("s2.done_cleared", 32'(done_a), 0);
        chk("s2.idx_restart", 32'(idx_a), 0);
        chk("s2.busy_restart", 32'(busy_a), 1);
        k = 0;
        while (cpu_rst_a && k < 100) begin
            k++;
            @(negedge clk);
        end
        repeat (119) @(negedge clk);
        halt_a = 1'b1;
        @(negedge clk);
        halt_a = 1'b0;
        wait_done(0, 1000, "s2");
        chk("s2.npulses", pn[0], 2);
        chk("s2.perf0", pp[0][0], 120);
        chk("s2.perf1", pp[0][1], 350);
        chk("s2.fwd1", pf[0][1], 0);

        // asynchronous reset in the 50th RUN cycle of run0
        clear_log(0);
        start_count(0, k);
        repeat (49) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("s3.cpu_rst", 32'(cpu_rst_a), 1);
        chk("s3.fwd", 32'(fwd_a), 1);
        chk("s3.busy", 32'(busy_a), 0);
        chk("s3.done", 32'(done_a), 0);
        chk("s3.perf_valid", 32'(pv_a), 0);
        chk("s3.perf_cycles", 32'(pc_a), 0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("s3.no_pulse", pn[0], 0);
        start_count(0, k);
        chk("s3.rerun_reset_len", k, 1);
        chk("s3.rerun_idx", 32'(idx_a), 0);
        wait_done(0, 1000, "s3");
        chk("s3.npulses", pn[0], 2);
        chk("s3.perf0", pp[0][0], 350);

        // four short runs, mask 1010, 3-cycle reset
        clear_log(1);
        start_count(1, k);
        chk("s4.reset_len", k, 3);
        wait_done(1, 500, "s4");
        chk("s4.npulses", pn[1], 4);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("s4.perf%0d", r), pp[1][r], 10);
            chk($sformatf("s4.fwd%0d", r), pf[1][r], r % 2);
            chk($sformatf("s4.idx%0d", r), pi[1][r], r);
        end

        // halt coincident with the last RUN cycle of run0
        clear_log(1);
        start_count(1, k);
        repeat (9) @(negedge clk);
        halt_b = 1'b1;
        @(negedge clk);
        halt_b = 1'b0;
        wait_done(1, 500, "s5");
        chk("s5.npulses", pn[1], 4);
        chk("s5.perf0", pp[1][0], 10);

        // halt held high for the whole sequence: every run lasts one cycle
        clear_log(1);
        halt_b = 1'b1;
        start_count(1, k);
        wait_done(1, 500, "s6");
        halt_b = 1'b0;
        chk("s6.npulses", pn[1], 4);
        chk("s6.perf0", pp[1][0], 1);
        chk("s6.perf3", pp[1][3], 1);
        chk("s6.fwd3", pf[1][3], 1);

        // randomized sequences, checked cycle by cycle against the model
        for (int it = 0; it < 6; it++) begin
            run_random(1, 500, 6);
            @(negedge clk);
        end
        for (int it = 0; it < 3; it++) begin
            run_random(0, 1500, 150);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
